set_mode_ctl: RTL and testbench
===============================

// Module: set_mode_ctl
// PURPOSE
// Edit-mode sequencer for the calendar/clock timer. Conditions the raw mode and plus
// push-buttons (sync, debounce, edge detect) and walks a one-hot field-select FSM
// IDLE->HOUR->DAY->MON->YEAR->IDLE. Issues single-cycle increment strobes with
// hold-to-auto-repeat, and returns to IDLE after an inactivity timeout. Produces a
// blink/blank flag so the scan path can flash the field being edited.
// PARAMETERS
// DEBOUNCE_TICKS  4'd8   ticks an input must hold its new level before it is accepted
// REPEAT_DELAY    10'd500 ticks plus must be held before auto-repeat starts
// REPEAT_RATE     10'd150 ticks between auto-repeat strobes
// TIMEOUT_TICKS   14'd10000 idle ticks in an edit state before forced return to IDLE
// BLINK_HALF      10'd250 ticks per blink half-period (on, then off)
// PORTS
// clk         in   1  system clock
// rst_n       in   1  asynchronous reset, ACTIVE-HIGH (port name kept for codebase consistency)
// tick        in   1  1-clk enable pulse from freq_div (nominal 1 kHz); all timing counts ticks
// button_raw  in   1  mode push-button, raw, active-low
// plus_raw    in   1  increment push-button, raw, active-low
// field_en    out  4  one-hot edit select {hour,day,mon,year} = [3:0]; 4'b0000 = IDLE
// plus_pulse  out  1  1-clk increment strobe to timer (only while field_en != 0)
// blank       out  1  1 = blank the selected field digits this phase
// edit_active out  1  |field_en
// BEHAVIOUR
// - Reset (async, rst_n=1): FSM=IDLE, field_en=0, plus_pulse=0, blank=0, edit_active=0.
//   All counters are 0. Debounced levels = released. Reset mid-edit aborts to IDLE.
// - Inputs pass through a 2-flop synchronizer, then are inverted to active-high.
// - Debounce: a per-input counter advances on tick while sync level != accepted level.
//   It clears whenever the two levels agree. At DEBOUNCE_TICKS the accepted level flips.
//   A press event is a 1-clk pulse on the accepted 0->1 edge.
// - FSM advances one state per button press event: IDLE->HOUR->DAY->MON->YEAR->IDLE.
//   field_en is registered, so it updates 1 clk after the press event.
// - plus handling (edit states only): a press event gives plus_pulse 1 clk later.
//   While plus stays held, a repeat counter runs on ticks. At REPEAT_DELAY it emits a
//   pulse, then one every REPEAT_RATE ticks. Release clears the counter.
//   Press events in IDLE are ignored entirely (no pulse, no state change).
// - Simultaneous button and plus press events in the same clk: button wins, the FSM
//   advances, no plus_pulse, and the repeat counter clears.
// - Entering a new field clears the repeat counter, so a held plus does not carry over.
// - Timeout counter: clears on any press event or FSM change, and counts ticks while
//   edit_active. At TIMEOUT_TICKS the FSM goes to IDLE and the counter clears.
// - Blink: a phase counter runs on ticks while edit_active. blank toggles each
//   BLINK_HALF ticks, starting at 0 on field entry.
//   Any plus_pulse forces blank=0 and restarts the phase, so the digits stay visible
//   while adjusting. In IDLE, blank=0.
// - Counter widths are sized to hold their parameter, and none wraps past its terminal
//   value: each saturates or clears as stated above.
// - At most one plus_pulse per clk, and plus_pulse is never asserted in IDLE.
// TESTING
// (bench: DEBOUNCE_TICKS=2, REPEAT_DELAY=6, REPEAT_RATE=3, TIMEOUT_TICKS=20, BLINK_HALF=4;
// tick high every clk)
// 1 Reset, hold rst_n=1 for 3 clk, release -> all outputs 0. Assert rst_n while in
//   DAY -> field_en=0 in the same clk (async).
// 2 Five clean button presses (low 5 clk, high 5 clk) -> field_en goes
//   1000,0100,0010,0001,0000. A 1-clk glitch low -> no change.
// 3 In HOUR, hold plus 20 clk -> one pulse at press, then pulses at ticks 6,9,12,15,18
//   after acceptance. Release -> no further pulses.
// 4 In IDLE, press plus -> plus_pulse stays 0, field_en stays 0.
// 5 In MON, no input for 20 ticks -> field_en=0000. blank toggles every 4 ticks before that.
// 6 Button and plus accepted in the same clk while in DAY -> field_en=0010, no plus_pulse.

Source files
------------

// File: rtl/set_mode_ctl_if.sv
// rtl/set_mode_ctl_if.sv - button/tick inputs and field-select outputs of set_mode_ctl
// Purpose: bundles the conditioned-button inputs and the edit-select outputs.
// Signals:
//   tick        1-clk timing enable (all timing counts ticks)
//   button_raw  raw mode button, active-low
//   plus_raw    raw increment button, active-low
//   field_en    one-hot field select {hour,day,mon,year}, 0 = idle
//   plus_pulse  1-clk increment strobe
//   blank       blank the selected field this phase
//   edit_active |field_en
// Modports: master drives the buttons/tick, slave is the sequencer.
interface set_mode_ctl_if;
  logic       tick;
  logic       button_raw;
  logic       plus_raw;
  logic [3:0] field_en;
  logic       plus_pulse;
  logic       blank;
  logic       edit_active;

  modport master (
    output tick, button_raw, plus_raw,
    input  field_en, plus_pulse, blank, edit_active
  );

  modport slave (
    input  tick, button_raw, plus_raw,
    output field_en, plus_pulse, blank, edit_active
  );
endinterface

// File: rtl/set_mode_ctl.sv
// rtl/set_mode_ctl.sv - edit-mode sequencer for the calendar/clock timer
// Purpose: synchronizes and debounces the mode and plus buttons, steps the
// field select IDLE->HOUR->DAY->MON->YEAR->IDLE, issues increment strobes with
// hold-to-repeat, times out back to IDLE and produces the field blink flag.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active-high despite the name
//   bus    set_mode_ctl_if.slave (tick, raw buttons in; field_en, plus_pulse,
//          blank, edit_active out)
module set_mode_ctl #(
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 150,
  parameter int unsigned TIMEOUT_TICKS  = 10000,
  parameter int unsigned BLINK_HALF     = 250
) (
  input logic           clk,
  input logic           rst_n,
  set_mode_ctl_if.slave bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
  // After a repeat strobe the counter restarts here so the next strobe lands
  // REPEAT_RATE ticks later without a second comparator.
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_DAY,
    S_MON,
    S_YEAR
  } state_t;

  // Index 0 = mode button, index 1 = plus button.
  logic [1:0]            raw;
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            level;
  logic [1:0]            acc_q;
  logic [1:0]            acc_prev_q;
  logic [1:0][DB_W-1:0]  db_cnt_q;

  state_t                state_q;
  logic [3:0]            field_en_q;
  logic                  plus_pulse_q;
  logic                  blank_q;
  logic [RP_W-1:0]       rep_cnt_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [BL_W-1:0]       blk_cnt_q;

  state_t                adv_state_d;
  logic [3:0]            adv_field_d;
  logic                  btn_press;
  logic                  plus_press;
  logic                  plus_held;
  logic                  rep_fire_d;
  logic                  to_expire_d;
  logic                  strobe_d;

  assign raw   = {bus.plus_raw, bus.button_raw};
  assign level = ~sync2_q;

  // Sync flops reset to the released (high) raw level so reset never looks
  // like a press.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      acc_q      <= 2'b00;
      acc_prev_q <= 2'b00;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int i = 0; i < 2; i++) begin
        if (level[i] == acc_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (bus.tick) begin
          if (db_cnt_q[i] == DB_LAST) begin
            acc_q[i]    <= level[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign btn_press  = acc_q[0] & ~acc_prev_q[0];
  assign plus_press = acc_q[1] & ~acc_prev_q[1];
  assign plus_held  = acc_q[1];

  always_comb begin
    adv_state_d = S_IDLE;
    adv_field_d = 4'b0000;
    case (state_q)
      S_IDLE: begin adv_state_d = S_HOUR; adv_field_d = 4'b1000; end
      S_HOUR: begin adv_state_d = S_DAY;  adv_field_d = 4'b0100; end
      S_DAY:  begin adv_state_d = S_MON;  adv_field_d = 4'b0010; end
      S_MON:  begin adv_state_d = S_YEAR; adv_field_d = 4'b0001; end
      default: begin adv_state_d = S_IDLE; adv_field_d = 4'b0000; end
    endcase
  end

  assign rep_fire_d  = plus_held & bus.tick & (rep_cnt_q == RP_LAST);
  // A plus press in the same clk counts as activity and wins over expiry.
  assign to_expire_d = bus.tick & ~plus_press & (to_cnt_q == TO_LAST);
  assign strobe_d    = plus_press | rep_fire_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      field_en_q   <= 4'b0000;
      plus_pulse_q <= 1'b0;
      blank_q      <= 1'b0;
      rep_cnt_q    <= '0;
      to_cnt_q     <= '0;
      blk_cnt_q    <= '0;
    end else begin
      plus_pulse_q <= 1'b0;
      if (btn_press) begin
        // Mode button wins over a coincident plus press; the plus press is dropped.
        state_q    <= adv_state_d;
        field_en_q <= adv_field_d;
        blank_q    <= 1'b0;
        rep_cnt_q  <= '0;
        to_cnt_q   <= '0;
        blk_cnt_q  <= '0;
      end else if (state_q == S_IDLE || to_expire_d) begin
        state_q    <= S_IDLE;
        field_en_q <= 4'b0000;
        blank_q    <= 1'b0;
        rep_cnt_q  <= '0;
        to_cnt_q   <= '0;
        blk_cnt_q  <= '0;
      end else begin
        plus_pulse_q <= strobe_d;

        if (!plus_held) begin
          rep_cnt_q <= '0;
        end else if (bus.tick) begin
          rep_cnt_q <= rep_fire_d ? RP_RELOAD : rep_cnt_q + 1'b1;
        end

        if (plus_press) begin
          to_cnt_q <= '0;
        end else if (bus.tick) begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end

        // Keep the digits visible while adjusting: every strobe restarts the
        // blink phase in the visible half.
        if (strobe_d) begin
          blank_q   <= 1'b0;
          blk_cnt_q <= '0;
        end else if (bus.tick) begin
          if (blk_cnt_q == BL_LAST) begin
            blank_q   <= ~blank_q;
            blk_cnt_q <= '0;
          end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.field_en    = field_en_q;
  assign bus.plus_pulse  = plus_pulse_q;
  assign bus.blank       = blank_q;
  assign bus.edit_active = |field_en_q;

endmodule

// File: tb/tb_set_mode_ctl.sv
// tb/tb_set_mode_ctl.sv - self-checking bench for set_mode_ctl
module tb_set_mode_ctl;

  localparam int DEB = 2;
  localparam int RD  = 6;
  localparam int RR  = 3;
  localparam int TO  = 20;
  localparam int BH  = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  set_mode_ctl_if bus ();

  set_mode_ctl #(
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR),
    .TIMEOUT_TICKS (TO),
    .BLINK_HALF    (BH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: field index 0..4, tick-count arithmetic for repeat,
  // timeout and blink phase.
  bit m_bh[2];
  bit m_ph[2];
  bit m_bacc, m_pacc;
  int m_bdiff, m_pdiff;
  bit m_brose, m_prose;
  int m_idx;
  int m_held;
  int m_idle;
  int m_phase;
  bit m_pulse;
  bit m_blank;

  int cyc;
  int obs_pulses;
  int pulse_log[$];
  bit stat_en;
  int mon_cycles;
  int blank_hi;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_field(input int idx);
    logic [3:0] one = 4'b1000;
    return (idx == 0) ? 4'b0000 : (one >> (idx - 1));
  endfunction

  task automatic model_reset();
    m_bh = '{1'b1, 1'b1};
    m_ph = '{1'b1, 1'b1};
    m_bacc = 0; m_pacc = 0;
    m_bdiff = 0; m_pdiff = 0;
    m_brose = 0; m_prose = 0;
    m_idx = 0; m_held = 0; m_idle = 0; m_phase = 0;
    m_pulse = 0; m_blank = 0;
  endtask

  task automatic debounce(input bit raw, inout bit hist[2], inout bit acc,
                          inout int diff, output bit rose, input bit t);
    bit lvl;
    lvl  = ~hist[1];
    rose = 0;
    if (lvl == acc) diff = 0;
    else if (t) begin
      diff++;
      if (diff == DEB) begin
        acc  = lvl;
        diff = 0;
        rose = lvl;
      end
    end
    hist[1] = hist[0];
    hist[0] = raw;
  endtask

  task automatic model_edge(input bit b, input bit p, input bit t);
    bit bpe, ppe, fire, strobe;
    bpe = m_brose;
    ppe = m_prose;
    m_pulse = 0;
    if (bpe) begin
      m_idx = (m_idx + 1) % 5;
      m_held = 0; m_idle = 0; m_phase = 0; m_blank = 0;
    end else if (m_idx == 0) begin
      m_held = 0; m_idle = 0; m_phase = 0; m_blank = 0;
    end else begin
      if (ppe) m_idle = 0;
      else if (t) m_idle++;
      if (m_idle == TO) begin
        m_idx = 0; m_held = 0; m_idle = 0; m_phase = 0; m_blank = 0;
      end else begin
        fire = 0;
        if (!m_pacc) m_held = 0;
        else if (t) begin
          m_held++;
          fire = (m_held == RD) || (m_held > RD && ((m_held - RD) % RR) == 0);
        end
        strobe  = ppe || fire;
        m_pulse = strobe;
        if (strobe) m_phase = 0;
        else if (t) m_phase++;
        m_blank = ((m_phase / BH) % 2) == 1;
      end
    end
    debounce(b, m_bh, m_bacc, m_bdiff, m_brose, t);
    debounce(p, m_ph, m_pacc, m_pdiff, m_prose, t);
  endtask

  task automatic step(input bit b, input bit p, input bit t);
    bus.button_raw = b;
    bus.plus_raw   = p;
    bus.tick       = t;
    @(posedge clk);
    model_edge(b, p, t);
    #1;
    cyc++;
    check("field_en", bus.field_en, exp_field(m_idx));
    check("plus_pulse", {3'b0, bus.plus_pulse}, {3'b0, m_pulse});
    check("blank", {3'b0, bus.blank}, {3'b0, m_blank});
    check("edit_active", {3'b0, bus.edit_active}, {3'b0, (m_idx != 0)});
    if (bus.plus_pulse === 1'b1) begin
      obs_pulses++;
      pulse_log.push_back(cyc);
    end
    if (stat_en && bus.field_en === 4'b0010) begin
      mon_cycles++;
      if (bus.blank === 1'b1) blank_hi++;
    end
  endtask

  task automatic hold(input bit b, input bit p, input int n);
    for (int i = 0; i < n; i++) step(b, p, 1'b1);
  endtask

  task automatic press_btn();
    hold(1'b0, 1'b1, 5);
    hold(1'b1, 1'b1, 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq_exp [5];
    int gap_exp [6];
    int guard;
    seq_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    gap_exp = '{0, 5, 8, 11, 14, 17};
    cyc = 0; obs_pulses = 0; stat_en = 0; mon_cycles = 0; blank_hi = 0;

    // Reset state
    rst_n = 1'b1;
    bus.button_raw = 1'b1;
    bus.plus_raw   = 1'b1;
    bus.tick       = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_field_en", bus.field_en, 4'b0000);
    check("rst_plus_pulse", {3'b0, bus.plus_pulse}, 4'b0000);
    check("rst_blank", {3'b0, bus.blank}, 4'b0000);
    check("rst_edit_active", {3'b0, bus.edit_active}, 4'b0000);
    rst_n = 1'b0;

    // Field walk and glitch rejection
    for (int k = 0; k < 5; k++) begin
      press_btn();
      check("press_seq", bus.field_en, seq_exp[k]);
    end
    step(1'b0, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 6);
    check("glitch", bus.field_en, 4'b0000);

    // Hold plus in HOUR: press strobe then repeats
    press_btn();
    check("t3_hour", bus.field_en, 4'b1000);
    obs_pulses = 0;
    pulse_log.delete();
    hold(1'b1, 1'b0, 20);
    hold(1'b1, 1'b1, 10);
    check_int("t3_count", obs_pulses, 6);
    if (pulse_log.size() == 6) begin
      for (int i = 0; i < 6; i++)
        check_int("t3_gap", pulse_log[i] - pulse_log[0], gap_exp[i]);
    end

    // Plus in IDLE is ignored
    hold(1'b1, 1'b1, 12);
    check("t4_idle_pre", bus.field_en, 4'b0000);
    obs_pulses = 0;
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 6);
    check_int("t4_pulses", obs_pulses, 0);
    check("t4_field", bus.field_en, 4'b0000);

    // MON timeout with blink
    press_btn();
    press_btn();
    stat_en = 1;
    press_btn();
    hold(1'b1, 1'b1, 25);
    stat_en = 0;
    check_int("t5_mon_cycles", mon_cycles, TO);
    check_int("t5_blank_hi", blank_hi, 8);
    check("t5_field", bus.field_en, 4'b0000);

    // Button and plus accepted together in DAY
    press_btn();
    press_btn();
    check("t6_day", bus.field_en, 4'b0100);
    obs_pulses = 0;
    hold(1'b0, 1'b0, 5);
    hold(1'b1, 1'b1, 8);
    check("t6_field", bus.field_en, 4'b0010);
    check_int("t6_pulses", obs_pulses, 0);

    // Randomized segments, tick mostly high
    for (int s = 0; s < 60; s++) begin
      bit rb, rp;
      int len;
      rb  = 1'($urandom_range(0, 1));
      rp  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) step(rb, rp, ($urandom_range(0, 7) != 0));
    end

    // Async reset from DAY
    hold(1'b1, 1'b1, 8);
    guard = 0;
    while (m_idx != 2 && guard < 12) begin
      press_btn();
      guard++;
    end
    check("t1_day", bus.field_en, 4'b0100);
    #2;
    rst_n = 1'b1;
    #1;
    check("t1_async_field", bus.field_en, 4'b0000);
    check("t1_async_edit", {3'b0, bus.edit_active}, 4'b0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    hold(1'b1, 1'b1, 5);
    check("t1_after", bus.field_en, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
